// File: rtl/ahblite_uart_tx_if.sv
// AHB-Lite slave port bundle for the UART transmitter.
// The master modport drives the request side; the slave modport returns ready/resp/read data.
interface ahblite_uart_tx_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_uart_tx.sv
// AHB-Lite UART transmitter: TX FIFO feeding an 8N1 LSB-first serialiser with a drain interrupt.
// Define UART_PARITY_EN to add the optional even-parity bit controlled by CTRL[1].
module ahblite_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RST   = 16'd433
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahblite_uart_tx_if.slave   bus,
  output logic               TXD,
  output logic               IRQ_TX
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Address phase capture; the data phase is always the following cycle (zero-wait)
  logic       r_dp_vld, r_dp_wr;
  logic [1:0] r_dp_addr;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_vld  <= 1'b0;
      r_dp_wr   <= 1'b0;
      r_dp_addr <= 2'd0;
    end else begin
      r_dp_vld  <= bus.HSEL & bus.HTRANS[1] & bus.HREADY;
      r_dp_wr   <= bus.HWRITE;
      r_dp_addr <= bus.HADDR[3:2];
    end
  end

  logic w_wr, w_rd, w_wr_data, w_wr_stat, w_wr_baud, w_wr_ctrl;
  assign w_wr      = r_dp_vld & r_dp_wr;
  assign w_rd      = r_dp_vld & ~r_dp_wr;
  assign w_wr_data = w_wr & (r_dp_addr == 2'd0);
  assign w_wr_stat = w_wr & (r_dp_addr == 2'd1);
  assign w_wr_baud = w_wr & (r_dp_addr == 2'd2);
  assign w_wr_ctrl = w_wr & (r_dp_addr == 2'd3);

  logic [15:0] r_baud;
  logic        r_irq_en;
  logic        w_par_en;

`ifdef UART_PARITY_EN
  logic r_par_en;
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)         r_par_en <= 1'b0;
    else if (w_wr_ctrl) r_par_en <= bus.HWDATA[1];
  end
  assign w_par_en = r_par_en;
`else
  assign w_par_en = 1'b0;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_baud   <= BAUD_RST;
      r_irq_en <= 1'b0;
    end else begin
      if (w_wr_baud) r_baud   <= bus.HWDATA[15:0];
      if (w_wr_ctrl) r_irq_en <= bus.HWDATA[0];
    end
  end

  // TX FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          w_full, w_empty, w_push, w_pop;
  logic [7:0]    w_head;
  state_t        r_state;
  logic [15:0]   r_timer, r_div;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rptr];
  assign w_pop   = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & (r_timer == '0)));
  // A full FIFO still accepts a byte when the serialiser pops in the same cycle
  assign w_push  = w_wr_data & (~w_full | w_pop);

  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr] <= bus.HWDATA[7:0];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
      if (w_wr_data & ~w_push)           r_ovf <= 1'b1;
      else if (w_wr_stat & bus.HWDATA[3]) r_ovf <= 1'b0;
    end
  end

  // Serialiser; r_txd is registered so TXD changes on the state-entry edge
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_par, r_txd;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_div    <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_txd    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_head;
            r_par   <= ^w_head;
            r_div   <= r_baud;
            r_timer <= r_baud;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_timer == '0) begin
            r_timer  <= r_div;
            r_bitcnt <= 3'd0;
            r_txd    <= r_shift[0];
            r_state  <= S_DATA;
          end else r_timer <= r_timer - 16'd1;
        end
        S_DATA: begin
          if (r_timer == '0) begin
            r_timer <= r_div;
            if (r_bitcnt == 3'd7) begin
              if (w_par_en) begin
                r_txd   <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_shift  <= r_shift >> 1;
              r_txd    <= r_shift[1];
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end else r_timer <= r_timer - 16'd1;
        end
        S_PARITY: begin
          if (r_timer == '0) begin
            r_timer <= r_div;
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end else r_timer <= r_timer - 16'd1;
        end
        S_STOP: begin
          if (r_timer == '0) begin
            if (!w_empty) begin
              r_shift <= w_head;
              r_par   <= ^w_head;
              r_div   <= r_baud;
              r_timer <= r_baud;
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else r_timer <= r_timer - 16'd1;
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  logic w_busy, r_irq;
  assign w_busy = (r_state != S_IDLE);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_irq <= 1'b0;
    else        r_irq <= r_irq_en & w_empty & ~w_busy;
  end

  assign TXD    = r_txd;
  assign IRQ_TX = r_irq;

  // Read mux
  logic [31:0] w_rdata;
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (r_dp_addr)
        2'd1:    w_rdata[7:0]  = {4'(r_count), r_ovf, w_busy, w_empty, w_full};
        2'd2:    w_rdata[15:0] = r_baud;
        2'd3:    w_rdata[1:0]  = {w_par_en, r_irq_en};
        default: w_rdata       = '0;
      endcase
    end
  end

  assign bus.HRDATA    = w_rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  logic w_unused;
  assign w_unused = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:16]};
endmodule
